// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-side memory bus initiator.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/mem_bus_master_checker.sv
// Bus-safety invariants for mem_bus_master.
module mem_bus_master_checker
  import mem_bus_pkg::*;
(
  input logic   clock,
  input logic   clear,
  input logic   mem_read,
  input logic   mem_write,
  input logic   drive_en,
  input state_e state
);

  // The two RAM strobes are mutually exclusive.
  a_strobe_excl: assert property (@(posedge clock) disable iff (clear)
    !(mem_read && mem_write));

  // The initiator never fights the RAM while the RAM is driving read data.
  a_no_drive_on_read: assert property (@(posedge clock) disable iff (clear)
    !(mem_read && drive_en));

  // Strobes belong to the ACCESS phase only.
  a_strobe_phase: assert property (@(posedge clock) disable iff (clear)
    (state != ACCESS) |-> !(mem_read || mem_write));

endmodule

// File: rtl/mem_bus_tristate.sv
// Bidirectional data pad: drives the shared bus when enabled, otherwise
// releases it, and always returns what is currently on the bus.
module mem_bus_tristate #(
  parameter int DATA_W = 32
) (
  input  logic              en,
  input  logic [DATA_W-1:0] out_val,
  inout  wire  [DATA_W-1:0] pad,
  output logic [DATA_W-1:0] in_val
);

  assign pad    = en ? out_val : {DATA_W{1'bz}};
  assign in_val = pad;

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the shared-bus RAM: one load or store at a time,
// sequenced as SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> DONE.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int               CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e              state_r;
  logic                dir_r;
  logic [CNT_W-1:0]    wait_cnt_r;
  logic [DATA_W-1:0]   data_r;
  logic                drive_en_r;
  logic [DATA_W-1:0]   bus_in_s;

  mem_bus_tristate #(.DATA_W(DATA_W)) u_data_pad (
    .en      (drive_en_r),
    .out_val (data_r),
    .pad     (mem_data),
    .in_val  (bus_in_s)
  );

  mem_bus_master_checker u_checker (
    .clock     (clock),
    .clear     (clear),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .drive_en  (drive_en_r),
    .state     (state_r)
  );

  // Transaction sequencer; owns every bus-facing and status register so all outputs are glitch-free.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r    <= IDLE;
      dir_r      <= DIR_RD;
      wait_cnt_r <= {CNT_W{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      drive_en_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      rd_data    <= {DATA_W{1'b0}};
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_read && req_write) begin
            // Ambiguous request: flag it and leave the bus alone.
            err <= 1'b1;
          end else if (req_read || req_write) begin
            state_r    <= SETUP;
            dir_r      <= req_write ? DIR_WR : DIR_RD;
            mem_addr   <= req_addr;
            data_r     <= wr_data;
            drive_en_r <= req_write;
            busy       <= 1'b1;
          end
        end
        SETUP: begin
          state_r    <= ACCESS;
          wait_cnt_r <= CNT_LOAD;
          mem_read   <= (dir_r == DIR_RD);
          mem_write  <= (dir_r == DIR_WR);
        end
        ACCESS: begin
          if (wait_cnt_r == {CNT_W{1'b0}}) begin
            state_r   <= HOLD;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (dir_r == DIR_RD) begin
              rd_data <= bus_in_s;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          // Store data stays on the bus through this cycle; release it on entry to DONE.
          state_r    <= DONE;
          drive_en_r <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          drive_en_r <= 1'b0;
          busy       <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized + directed bench for mem_bus_master with a transaction-level
// reference model (offsets from acceptance, model RAM and model MDR).
module tb_mem_bus_master;

  localparam int W  = 1;
  localparam int W3 = 3;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_read, req_write;
  logic [8:0]  req_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy, done, err, mem_read, mem_write;
  logic [8:0]  mem_addr;
  wire  [31:0] mem_data;

  // second instance with a longer access phase
  logic        r3, w3;
  logic [8:0]  a3;
  logic [31:0] d3;
  logic [31:0] rd3;
  logic        busy3, done3, err3, m3_read, m3_write;
  logic [8:0]  m3_addr;
  wire  [31:0] bus3;

  always #5 clock = ~clock;

  mem_bus_master #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clock(clock), .clear(clear), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .err(err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  mem_bus_master #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W3)) dut3 (
    .clock(clock), .clear(clear), .req_read(r3), .req_write(w3),
    .req_addr(a3), .wr_data(d3), .rd_data(rd3), .busy(busy3),
    .done(done3), .err(err3), .mem_read(m3_read), .mem_write(m3_write),
    .mem_addr(m3_addr), .mem_data(bus3)
  );

  function automatic logic [31:0] init_word(logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // ---------------- physical RAM (level-sensitive, low 8 address bits backed)
  logic [31:0] ram    [256];
  bit          ram_wr [256];
  logic [31:0] ram_rd_s, tb_val_s;
  logic        tb_en_s;
  logic        probe_en = 1'b1;   // drives 0 onto the bus whenever the DUT should have released it

  assign ram_rd_s = ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_word(mem_addr[7:0]);
  assign tb_en_s  = mem_read | probe_en;
  assign tb_val_s = mem_read ? ram_rd_s : 32'h0;
  assign mem_data = tb_en_s ? tb_val_s : {32{1'bz}};

  logic        b3_en;
  logic [31:0] b3_val;
  assign b3_en  = m3_read;
  assign b3_val = (m3_addr == 9'h000) ? 32'hA8800000 : 32'h0;
  assign bus3   = b3_en ? b3_val : {32{1'bz}};

  always @(posedge clock) begin
    if (mem_write) begin
      ram[mem_addr[7:0]]    <= mem_data;
      ram_wr[mem_addr[7:0]] <= 1'b1;
    end
  end

  // ---------------- reference model state
  int          tests = 0, fails = 0;
  int          t = 0;
  bit          act = 1'b0;
  int          acc_t = 0;
  bit          act_wr;
  logic [8:0]  act_addr;
  logic [31:0] act_data;
  logic [8:0]  last_addr = 9'h0;
  logic [31:0] mdr = 32'h0;
  int          err_at = -1;
  logic [31:0] mref [256];
  int          done_seen = 0, wr_seen = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @iter %0d: got %h expected %h", name, t, got, exp);
    end
  endtask

  // Compare every DUT output against what the transaction model says for this cycle.
  task automatic check_cycle();
    int k = 0;
    logic e_busy = 1'b0, e_done = 1'b0, e_rd = 1'b0, e_wr = 1'b0, e_drv = 1'b0, e_err;
    logic [31:0] e_bus;
    if (act && (t - acc_t) > W + 3) act = 1'b0;
    if (act) begin
      k      = t - acc_t;
      e_busy = (k >= 1) && (k <= W + 2);
      e_done = (k == W + 3);
      e_rd   = !act_wr && (k >= 2) && (k <= W + 1);
      e_wr   =  act_wr && (k >= 2) && (k <= W + 1);
      e_drv  =  act_wr && (k >= 1) && (k <= W + 2);
      if (k == 1) last_addr = act_addr;
      if (k == W + 2) begin
        if (act_wr) mref[act_addr[7:0]] = act_data;
        else        mdr = mref[act_addr[7:0]];
      end
    end
    e_err = (t == err_at);
    e_bus = e_drv ? act_data : (e_rd ? mref[last_addr[7:0]] : 32'h0);
    probe_en = !e_drv;
    #1;
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
    chk("err",       32'(err),       32'(e_err));
    chk("mem_read",  32'(mem_read),  32'(e_rd));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("mem_addr",  32'(mem_addr),  32'(last_addr));
    chk("mem_data",  mem_data,       e_bus);
    chk("rd_data",   rd_data,        mdr);
    done_seen += int'(done);
    wr_seen   += int'(mem_write);
  endtask

  task automatic drive(bit r, bit w, logic [8:0] a, logic [31:0] d);
    req_read = r; req_write = w; req_addr = a; wr_data = d;
    if (!act && !clear) begin
      if (r ^ w) begin
        act = 1'b1; acc_t = t; act_wr = w; act_addr = a; act_data = d;
      end else if (r && w) begin
        err_at = t + 1;
      end
    end
  endtask

  task automatic tick(bit r, bit w, logic [8:0] a, logic [31:0] d);
    @(negedge clock);
    t++;
    check_cycle();
    drive(r, w, a, d);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 9'h000, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d0, w0, reads, done_k;
    int pick;
    for (int i = 0; i < 256; i++) mref[i] = init_word(8'(i));
    clear = 1'b1;
    req_read = 1'b0; req_write = 1'b0; req_addr = 9'h0; wr_data = 32'h0;
    r3 = 1'b0; w3 = 1'b0; a3 = 9'h0; d3 = 32'h0;

    // reset state
    idle(); idle();
    chk("rst_busy",  32'(busy),     32'h0);
    chk("rst_rd",    rd_data,       32'h0);
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_read",  32'(mem_read), 32'h0);
    chk("rst_bus",   mem_data,      32'h0);
    clear = 1'b0;
    idle();

    // store 0x55 <- 2, then load it back
    w0 = wr_seen;
    tick(1'b0, 1'b1, 9'h055, 32'h00000002); s = t;
    idle(); chk("st_setup_wr", 32'(mem_write), 32'h0); chk("st_setup_bus", mem_data, 32'h2);
    idle(); chk("st_acc_wr",   32'(mem_write), 32'h1); chk("st_acc_bus",   mem_data, 32'h2);
    idle(); chk("st_hold_wr",  32'(mem_write), 32'h0); chk("st_hold_bus",  mem_data, 32'h2);
    idle(); chk("st_done_c4",  32'(done),      32'h1); chk("st_done_k",    32'(t - s), 32'd4);
    chk("st_wr_cycles", 32'(wr_seen - w0), 32'd1);
    tick(1'b1, 1'b0, 9'h055, 32'h0);
    repeat (4) idle();
    chk("ld_done", 32'(done), 32'h1);
    chk("ld_rd",   rd_data,   32'h00000002);

    // both requests high -> err only
    w0 = wr_seen;
    tick(1'b1, 1'b1, 9'h010, 32'hFFFFFFFF);
    idle(); chk("both_err", 32'(err), 32'h1); chk("both_busy", 32'(busy), 32'h0);
    idle(); chk("both_err_pulse", 32'(err), 32'h0);
    chk("both_no_wr", 32'(wr_seen - w0), 32'd0);
    tick(1'b1, 1'b0, 9'h010, 32'h0);
    repeat (4) idle();
    chk("both_ram_kept", rd_data, init_word(8'h10));

    // repeated write requests during an active store are ignored
    d0 = done_seen; w0 = wr_seen;
    tick(1'b0, 1'b1, 9'h05A, 32'h11111111);
    tick(1'b0, 1'b1, 9'h05A, 32'h22222222);
    tick(1'b0, 1'b1, 9'h05B, 32'h33333333);
    repeat (4) idle();
    chk("ign_done_cnt", 32'(done_seen - d0), 32'd1);
    chk("ign_wr_cnt",   32'(wr_seen - w0),   32'd1);
    tick(1'b1, 1'b0, 9'h05A, 32'h0);
    repeat (4) idle();
    chk("ign_rd", rd_data, 32'h11111111);

    // clear in the middle of a load
    tick(1'b1, 1'b0, 9'h033, 32'h0);
    idle();
    idle(); chk("clr_pre_read", 32'(mem_read), 32'h1);
    #2;
    clear = 1'b1;
    act = 1'b0; mdr = 32'h0; last_addr = 9'h0; err_at = -1; probe_en = 1'b1;
    #1;
    chk("clr_async_read",  32'(mem_read),  32'h0);
    chk("clr_async_write", 32'(mem_write), 32'h0);
    chk("clr_async_busy",  32'(busy),      32'h0);
    chk("clr_async_bus",   mem_data,       32'h0);
    chk("clr_async_rd",    rd_data,        32'h0);
    d0 = done_seen;
    idle(); idle();
    clear = 1'b0;
    repeat (5) idle();
    chk("clr_no_done", 32'(done_seen - d0), 32'd0);
    tick(1'b1, 1'b0, 9'h033, 32'h0);
    repeat (4) idle();
    chk("clr_next_done", 32'(done), 32'h1);
    chk("clr_next_rd",   rd_data,   init_word(8'h33));

    // randomized traffic, including requests while busy and both-high
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 9));
      tick(pick <= 2 || pick == 6, (pick >= 3 && pick <= 6),
           {1'($urandom_range(0, 1)), 4'b0000, 4'($urandom_range(0, 15))}, $urandom);
    end
    repeat (8) idle();

    // longer access phase instance: load addr 0
    reads = 0; done_k = -1;
    idle();
    r3 = 1'b1; a3 = 9'h000;
    for (int i = 1; i <= 10; i++) begin
      idle();
      if (i == 1) r3 = 1'b0;
      reads += int'(m3_read);
      if (done3) done_k = i;
    end
    chk("w3_read_cycles", 32'(reads),  32'd3);
    chk("w3_done_k",      32'(done_k), 32'd6);
    chk("w3_rd",          rd3,         32'hA8800000);
    chk("w3_busy_end",    32'(busy3),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
